trivium_sequencer: RTL and testbench
====================================

Name: trivium_sequencer

Overview:
Controller that runs the Trivium keystream core as a multi-block generator. One start command (key, base IV, block count) becomes a series of core runs. For each run the block resets the core with the current IV, waits for end-of-block, and hands the keystream word downstream over a valid/ready interface. It then increments the IV and repeats. It sits between the autotest/host logic and trivium_wrapper, replacing direct drive of the core's rst/key/iv.

Parameters:
DATA_WIDTH, 64, keystream word width; matches trivium_wrapper DATA_WIDTH
KEY_WIDTH, 80, key width
IV_WIDTH, 80, IV width
CNT_WIDTH, 16, width of block count and block index
RST_CYCLES, 2, cycles uut_rst_o is held high per run (>=1)
TIMEOUT, 4096, max cycles in WAIT_END before error (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start_i  in  1  start command pulse; sampled only when not busy
key_i  in  KEY_WIDTH  key; captured on accepted start
iv_i  in  IV_WIDTH  base IV; captured on accepted start
n_blocks_i  in  CNT_WIDTH  number of blocks; captured on accepted start
busy_o  out  1  high in every state except IDLE/DONE/ERROR
done_o  out  1  one-cycle pulse when all blocks have been delivered
error_o  out  1  sticky timeout flag; cleared by next accepted start
uut_rst_o  out  1  active-high reset to trivium_wrapper
uut_key_o  out  KEY_WIDTH  key to core
uut_iv_o  out  IV_WIDTH  current IV to core
uut_end_i  in  1  core end_block
uut_block_i  in  DATA_WIDTH  core block_o
block_o  out  DATA_WIDTH  captured keystream word
block_idx_o  out  CNT_WIDTH  index of block_o (0-based)
block_valid_o  out  1  block_o valid
block_ready_i  in  1  downstream accept

Behaviour:
- Reset (rst=0, async): state IDLE; uut_rst_o=1; key, IV, count, index, block_o = 0; block_valid_o, done_o, error_o, busy_o = 0.
- States: IDLE, RESET_UUT, WAIT_END, OUTPUT, NEXT, DONE, ERROR. DONE and ERROR behave as IDLE for start acceptance.
- Start accepted in IDLE/DONE/ERROR when start_i=1:
  - Capture key, IV, n_blocks; index := 0; error_o := 0.
  - If n_blocks_i = 0: go to DONE, done_o pulses next cycle, core untouched.
  - Otherwise: go to RESET_UUT.
- start_i while busy: ignored, no effect.
- RESET_UUT: uut_rst_o=1 for exactly RST_CYCLES cycles, then WAIT_END with uut_rst_o=0. uut_key_o/uut_iv_o are stable from the first RESET_UUT cycle until leaving WAIT_END.
- WAIT_END:
  - Timeout counter starts at 0 and increments each cycle.
  - uut_end_i=1: register uut_block_i into block_o, set block_valid_o=1, go to OUTPUT.
  - Counter reaches TIMEOUT-1 without uut_end_i: go to ERROR; error_o=1, uut_rst_o=1, no done_o.
  - uut_end_i is ignored while uut_rst_o=1.
- OUTPUT: hold block_o, block_idx_o and block_valid_o until block_ready_i=1 (arbitrary backpressure). On the handshake cycle block_valid_o falls next edge, then go to NEXT.
- NEXT (1 cycle):
  - If index = count-1: go to DONE, done_o pulse for 1 cycle.
  - Else: index+1 and IV+1 (mod 2^IV_WIDTH, wraps all-ones to 0), then go to RESET_UUT.
- IDLE/DONE/ERROR: uut_rst_o=1, keeping the core quiescent.
- Latency, start accepted at edge 0:
  - uut_rst_o high through edges 1..RST_CYCLES.
  - WAIT_END from edge RST_CYCLES+1.
  - block_valid_o rises one edge after uut_end_i is sampled.
- Per-block overhead: RST_CYCLES + 2 cycles plus core time and backpressure.
- Async reset mid-run: immediate return to reset values; partial block discarded; done_o never asserted.

Decomposition:
- Package trivium_seq_pkg: state enum type; default width constants (KEY_WIDTH, IV_WIDTH, DATA_WIDTH).
- Sub-module: none required. Optional trivium_seq_timeout holds the WAIT_END watchdog counter (clear/enable in, expired out); the FSM and datapath registers stay in trivium_sequencer.

Test Plan:
- Single block, DATA_WIDTH=64, TIMEOUT=4096, RST_CYCLES=2 (defaults unless stated):
  - Stimulus: key=0x0, iv=0x0, n=1; core model asserts end 50 cycles after reset release with block 0xFBE0BF265859051B.
  - Required: block_o = that value, idx=0; uut_rst_o high exactly 2 cycles; done_o one pulse; busy_o low afterwards.
- Multi-block IV sequencing:
  - Stimulus: iv=0x...FFFF_FFFE, n=3.
  - Required: core sees IVs ...FFFE, ...FFFF, 0x0 (wrap); idx_o = 0, 1, 2; exactly 3 handshakes then done_o.
- Backpressure:
  - Stimulus: n=2; block_ready_i low 20 cycles after first valid.
  - Required: block_o/idx stable and valid held high throughout; second core reset only after handshake.
- Timeout:
  - Stimulus: TIMEOUT=16; core never asserts end.
  - Required: ERROR 16 cycles after WAIT_END entry; error_o=1, uut_rst_o=1, no done_o.
  - Follow-up: next start clears error_o.
- Zero count and start while busy:
  - Stimulus: n=0.
  - Required: done_o next cycle, uut_rst_o never deasserts.
  - Stimulus: start_i pulsed mid-run with a different key.
  - Required: ignored; uut_key_o unchanged.
- Async reset mid-run:
  - Stimulus: rst=0 during OUTPUT of block 1 of 3.
  - Required: all outputs return to reset values immediately; no done_o; a fresh start then runs normally.

Source files
------------

// File: rtl/trivium_seq_pkg.sv
// Shared state type and default widths for the Trivium multi-block sequencer.
package trivium_seq_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_KEY_WIDTH  = 80;
    localparam int unsigned DEF_IV_WIDTH   = 80;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_UUT = 3'd1,
        ST_WAIT_END  = 3'd2,
        ST_OUTPUT    = 3'd3,
        ST_NEXT      = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/trivium_seq_timeout.sv
// Watchdog counter bounding how long the sequencer waits for the core's end-of-block.
module trivium_seq_timeout #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    assign expired_c = (count == CW'(TIMEOUT - 1));

    // Count cycles spent waiting; saturate at the limit, restart whenever cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired_c) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/trivium_sequencer.sv
// Runs the Trivium core once per block: reset with current IV, wait for end,
// hand the keystream word downstream, bump the IV, repeat until the count is met.
module trivium_sequencer
    import trivium_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter int unsigned IV_WIDTH   = DEF_IV_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [KEY_WIDTH-1:0]  key_i,
    input  logic [IV_WIDTH-1:0]   iv_i,
    input  logic [CNT_WIDTH-1:0]  n_blocks_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  uut_rst_o,
    output logic [KEY_WIDTH-1:0]  uut_key_o,
    output logic [IV_WIDTH-1:0]   uut_iv_o,
    input  logic                  uut_end_i,
    input  logic [DATA_WIDTH-1:0] uut_block_i,
    output logic [DATA_WIDTH-1:0] block_o,
    output logic [CNT_WIDTH-1:0]  block_idx_o,
    output logic                  block_valid_o,
    input  logic                  block_ready_i
);

    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_t           state;
    logic [CNT_WIDTH-1:0] count;
    logic [RCW-1:0]       rst_cnt;
    logic                 waiting;
    logic                 expired;

    assign waiting = (state == ST_WAIT_END);

    trivium_seq_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear     (!waiting),
        .enable    (waiting),
        .expired_c (expired)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            count         <= '0;
            rst_cnt       <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            uut_rst_o     <= 1'b1;
            uut_key_o     <= '0;
            uut_iv_o      <= '0;
            block_o       <= '0;
            block_idx_o   <= '0;
            block_valid_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    uut_rst_o <= 1'b1;
                    busy_o    <= 1'b0;
                    if (start_i) begin
                        uut_key_o   <= key_i;
                        uut_iv_o    <= iv_i;
                        count       <= n_blocks_i;
                        block_idx_o <= '0;
                        error_o     <= 1'b0;
                        rst_cnt     <= '0;
                        if (n_blocks_i == '0) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= ST_RESET_UUT;
                            busy_o <= 1'b1;
                        end
                    end
                end
                ST_RESET_UUT: begin
                    if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
                        state     <= ST_WAIT_END;
                        uut_rst_o <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RCW'(1);
                    end
                end
                ST_WAIT_END: begin
                    if (uut_end_i && !uut_rst_o) begin
                        block_o       <= uut_block_i;
                        block_valid_o <= 1'b1;
                        state         <= ST_OUTPUT;
                    end else if (expired) begin
                        state     <= ST_ERROR;
                        error_o   <= 1'b1;
                        uut_rst_o <= 1'b1;
                        busy_o    <= 1'b0;
                    end
                end
                ST_OUTPUT: begin
                    if (block_ready_i) begin
                        block_valid_o <= 1'b0;
                        state         <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    uut_rst_o <= 1'b1;
                    if (block_idx_o == (count - CNT_WIDTH'(1))) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end else begin
                        block_idx_o <= block_idx_o + CNT_WIDTH'(1);
                        uut_iv_o    <= uut_iv_o + IV_WIDTH'(1);
                        rst_cnt     <= '0;
                        state       <= ST_RESET_UUT;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy_o    <= 1'b0;
                    uut_rst_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_sequencer.sv
// Directed bench for trivium_sequencer with a simple behavioural core responder.
module tb_trivium_sequencer;

    localparam logic [63:0] REF_BLOCK  = 64'hFBE0BF265859051B;
    localparam int          CORE_DELAY = 50;
    localparam int          BUDGET     = 500;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        start_t = 1'b0;
    logic [79:0] key_i = '0;
    logic [79:0] iv_i = '0;
    logic [15:0] n_blocks_i = '0;
    logic        block_ready_i = 1'b0;

    logic        busy_o, done_o, error_o, uut_rst_o, block_valid_o;
    logic [79:0] uut_key_o, uut_iv_o;
    logic [63:0] block_o, uut_block_i;
    logic [15:0] block_idx_o;
    logic        uut_end_i = 1'b0;

    logic        to_busy, to_done, to_error, to_uut_rst, to_valid;
    logic [79:0] to_uut_key, to_uut_iv;
    logic [63:0] to_block;
    logic [15:0] to_idx;

    int vectors = 0;
    int miscompares = 0;
    int core_cnt = 0;
    int done_cnt = 0;
    int to_done_cnt = 0;
    int hs_cnt = 0;
    int rst_run = 0;
    int last_run = 0;
    int d0, hs0, cyc;
    logic        rst_low;
    logic [79:0] exp_iv [3];
    logic [63:0] exp_blk [3];

    trivium_sequencer #(
        .DATA_WIDTH(64), .KEY_WIDTH(80), .IV_WIDTH(80), .CNT_WIDTH(16),
        .RST_CYCLES(2), .TIMEOUT(4096)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .key_i(key_i), .iv_i(iv_i),
        .n_blocks_i(n_blocks_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .uut_rst_o(uut_rst_o), .uut_key_o(uut_key_o), .uut_iv_o(uut_iv_o),
        .uut_end_i(uut_end_i), .uut_block_i(uut_block_i), .block_o(block_o),
        .block_idx_o(block_idx_o), .block_valid_o(block_valid_o),
        .block_ready_i(block_ready_i)
    );

    trivium_sequencer #(
        .DATA_WIDTH(64), .KEY_WIDTH(80), .IV_WIDTH(80), .CNT_WIDTH(16),
        .RST_CYCLES(2), .TIMEOUT(16)
    ) dut_to (
        .clk(clk), .rst(rst), .start_i(start_t), .key_i(key_i), .iv_i(iv_i),
        .n_blocks_i(n_blocks_i), .busy_o(to_busy), .done_o(to_done), .error_o(to_error),
        .uut_rst_o(to_uut_rst), .uut_key_o(to_uut_key), .uut_iv_o(to_uut_iv),
        .uut_end_i(1'b0), .uut_block_i(64'h0), .block_o(to_block),
        .block_idx_o(to_idx), .block_valid_o(to_valid),
        .block_ready_i(block_ready_i)
    );

    always #5 clk = ~clk;

    // Core responder: end pulse CORE_DELAY cycles after reset release; word depends on IV.
    assign uut_block_i = REF_BLOCK ^ uut_iv_o[63:0];
    always @(posedge clk) begin
        if (!rst || uut_rst_o) begin
            core_cnt  <= 0;
            uut_end_i <= 1'b0;
        end else begin
            core_cnt  <= core_cnt + 1;
            uut_end_i <= (core_cnt == CORE_DELAY - 1);
        end
    end

    // Event monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (to_done) to_done_cnt++;
        if (block_valid_o && block_ready_i) hs_cnt++;
        if (uut_rst_o) begin
            rst_run++;
        end else begin
            if (rst_run != 0) last_run = rst_run;
            rst_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (block_valid_o !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        chk(tag, 128'(block_valid_o), 128'(1));
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (done_o !== 1'b1 && c < BUDGET) begin
            step();
            c++;
        end
        chk(tag, 128'(done_o), 128'(1));
    endtask

    task automatic start_main(input logic [79:0] k, input logic [79:0] v, input logic [15:0] n);
        key_i = k; iv_i = v; n_blocks_i = n; start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        exp_iv[0] = 80'hFFFF_FFFF_FFFF_FFFF_FFFE;
        exp_iv[1] = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        exp_iv[2] = 80'h0;
        exp_blk[0] = 64'h041F40D9A7A6FAE5;
        exp_blk[1] = 64'h041F40D9A7A6FAE4;
        exp_blk[2] = 64'hFBE0BF265859051B;

        // Reset values
        repeat (3) step();
        chk("rst_flags", 128'({busy_o, done_o, error_o, block_valid_o, uut_rst_o}), 128'(5'b00001));
        chk("rst_data", 128'({block_o, block_idx_o}), 128'(0));
        chk("rst_keyiv", {uut_key_o, uut_iv_o[47:0]}, 128'(0));
        rst = 1'b1;
        step();

        // Single block, key 0 / iv 0
        block_ready_i = 1'b1;
        d0 = done_cnt;
        start_main(80'h0, 80'h0, 16'd1);
        chk("t1_busy", 128'({busy_o, uut_rst_o, done_o}), 128'(3'b110));
        step();
        chk("t1_rst_c2", 128'(uut_rst_o), 128'(1));
        step();
        chk("t1_rst_rel", 128'(uut_rst_o), 128'(0));
        wait_valid("t1_valid", cyc);
        chk("t1_latency", 128'(cyc), 128'(CORE_DELAY + 1));
        chk("t1_block", 128'(block_o), 128'(REF_BLOCK));
        chk("t1_idx", 128'(block_idx_o), 128'(0));
        step();
        chk("t1_valid_fall", 128'(block_valid_o), 128'(0));
        wait_done("t1_done");
        chk("t1_idle", 128'({busy_o, uut_rst_o}), 128'(2'b01));
        repeat (3) step();
        chk("t1_done_pulses", 128'(done_cnt - d0), 128'(1));

        // Multi-block IV sequencing with wrap, plus start while busy
        d0 = done_cnt;
        hs0 = hs_cnt;
        start_main(80'h1234, exp_iv[0], 16'd3);
        for (int k = 0; k < 3; k++) begin
            wait_valid("t2_valid", cyc);
            chk("t2_block", 128'(block_o), 128'(exp_blk[k]));
            chk("t2_idx", 128'(block_idx_o), 128'(k));
            chk("t2_iv", 128'(uut_iv_o), 128'(exp_iv[k]));
            if (k > 0) chk("t2_rst_len", 128'(last_run), 128'(2));
            step();
            if (k == 0) begin
                start_main(80'hDEAD, 80'h9, 16'd0);
                chk("t2_busy_start", 128'({uut_key_o, busy_o, done_o}), 128'({80'h1234, 2'b10}));
            end
        end
        wait_done("t2_done");
        chk("t2_handshakes", 128'(hs_cnt - hs0), 128'(3));
        step();
        chk("t2_done_pulses", 128'(done_cnt - d0), 128'(1));

        // Backpressure
        block_ready_i = 1'b0;
        start_main(80'h0, 80'h5, 16'd2);
        wait_valid("t3_valid0", cyc);
        for (int i = 0; i < 20; i++) begin
            chk("t3_hold", 128'({block_valid_o, block_idx_o, block_o, uut_rst_o}),
                128'({1'b1, 16'd0, 64'hFBE0BF265859051E, 1'b0}));
            step();
        end
        block_ready_i = 1'b1;
        step();
        chk("t3_valid_fall", 128'(block_valid_o), 128'(0));
        wait_valid("t3_valid1", cyc);
        chk("t3_block1", 128'({block_idx_o, block_o}), 128'({16'd1, 64'hFBE0BF265859051D}));
        chk("t3_rst_len", 128'(last_run), 128'(2));
        step();
        wait_done("t3_done");

        // Timeout on the short-watchdog instance
        key_i = 80'hABCD; iv_i = 80'h0; n_blocks_i = 16'd1; start_t = 1'b1;
        step();
        start_t = 1'b0;
        chk("t4_capture", 128'({to_uut_key, to_uut_iv[15:0]}), 128'({80'hABCD, 16'h0}));
        chk("t4_start", 128'({to_busy, to_uut_rst}), 128'(2'b11));
        step();
        step();
        chk("t4_wait_entry", 128'(to_uut_rst), 128'(0));
        repeat (15) step();
        chk("t4_pre_err", 128'({to_error, to_busy}), 128'(2'b01));
        step();
        chk("t4_error", 128'({to_error, to_uut_rst, to_busy}), 128'(3'b110));
        chk("t4_no_block", 128'({to_valid, to_idx, to_block}), 128'(0));
        step();
        chk("t4_no_done", 128'(to_done_cnt), 128'(0));
        n_blocks_i = 16'd0; start_t = 1'b1;
        step();
        start_t = 1'b0;
        chk("t4_err_clear", 128'({to_error, to_done}), 128'(2'b01));

        // Zero block count
        start_main(80'h77, 80'h0, 16'd0);
        chk("t5_zero", 128'({done_o, busy_o, uut_rst_o}), 128'(3'b101));
        chk("t5_key", 128'(uut_key_o), 128'(80'h77));
        rst_low = 1'b0;
        repeat (10) begin
            step();
            if (!uut_rst_o) rst_low = 1'b1;
        end
        chk("t5_rst_held", 128'({rst_low, done_o}), 128'(0));

        // Async reset during output of the second block
        d0 = done_cnt;
        block_ready_i = 1'b1;
        start_main(80'h0, 80'h0, 16'd3);
        wait_valid("t6_valid0", cyc);
        step();
        block_ready_i = 1'b0;
        wait_valid("t6_valid1", cyc);
        chk("t6_idx1", 128'({block_idx_o, block_o}), 128'({16'd1, 64'hFBE0BF265859051A}));
        #2 rst = 1'b0;
        #1;
        chk("t6_async_flags", 128'({busy_o, done_o, error_o, block_valid_o, uut_rst_o}), 128'(5'b00001));
        chk("t6_async_data", 128'({block_o, block_idx_o}), 128'(0));
        chk("t6_async_iv", 128'(uut_iv_o), 128'(0));
        step();
        rst = 1'b1;
        block_ready_i = 1'b1;
        repeat (5) step();
        chk("t6_no_done", 128'(done_cnt - d0), 128'(0));
        start_main(80'h0, 80'h0, 16'd1);
        wait_valid("t6_fresh_valid", cyc);
        chk("t6_fresh_block", 128'({block_idx_o, block_o}), 128'({16'd0, REF_BLOCK}));
        step();
        wait_done("t6_fresh_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
